// File: rtl/boot_loader_if.sv
// Loader bus bundle: UART RX handshake, RAM write port and core/status signals.
interface boot_loader_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              reboot;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic [3:0]        ld_wmask;
  logic              core_resetn;
  logic              busy;
  logic              done;
  logic              error;

  // Environment side: byte source, reboot request, RAM/core observer.
  modport master (
    output rx_data, rx_valid, reboot,
    input  rx_ready, ld_we, ld_addr, ld_wdata, ld_wmask,
    input  core_resetn, busy, done, error
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid, reboot,
    output rx_ready, ld_we, ld_addr, ld_wdata, ld_wmask,
    output core_resetn, busy, done, error
  );
endinterface

// File: rtl/boot_loader.sv
// Power-up program loader: length, little-endian words to RAM, XOR checksum, core release.
module boot_loader #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic          clk,
  input  logic          reset,
  boot_loader_if.slave  bus
);

  localparam int unsigned WIDX_W    = ADDR_W + 1;
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_SUM  = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [31:0]       n_q, n_d;
  logic [1:0]        bsel_q, bsel_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        xor_q, xor_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              resetn_q, resetn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              rx_ready_c;
  logic              acc_c;
  logic              len_done_c;
  logic              word_done_c;
  logic              last_word_c;
  logic              sum_ok_c;
  logic [31:0]       n_full_c;
  logic [WIDX_W-1:0] widx_inc_c;

  assign acc_c = bus.rx_valid & rx_ready_c;

  // Transfer-level events shared by the FSM and the datapath.
  always_comb begin
    n_full_c    = {bus.rx_data, n_q[23:0]};
    widx_inc_c  = widx_q + WIDX_W'(1);
    len_done_c  = (state_q == S_LEN)  && acc_c && (bsel_q == 2'd3);
    word_done_c = (state_q == S_DATA) && acc_c && (bsel_q == 2'd3);
    last_word_c = (32'(widx_inc_c) == n_q);
    sum_ok_c    = (bus.rx_data == xor_q);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; reboot overrides any byte accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    if (bus.reboot) begin
      state_d = S_LEN;
    end else begin
      case (state_q)
        S_LEN: begin
          if (len_done_c) begin
            if ({1'b0, n_full_c} > MAX_WORDS) begin
              state_d = S_ERR;
            end else if (n_full_c == 32'd0) begin
              state_d = S_SUM;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_done_c && last_word_c) begin
            state_d = S_SUM;
          end
        end
        S_SUM: begin
          if (acc_c) begin
            state_d = sum_ok_c ? S_RUN : S_ERR;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output decode: live rx_ready, next values of the registered status flags.
  always_comb begin
    rx_ready_c = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    resetn_d   = 1'b0;
    case (state_q)
      S_LEN, S_DATA, S_SUM: rx_ready_c = 1'b1;
      default:              rx_ready_c = 1'b0;
    endcase
    case (state_d)
      S_LEN, S_DATA, S_SUM: busy_d = 1'b1;
      S_RUN: begin
        done_d   = 1'b1;
        resetn_d = 1'b1;
      end
      S_ERR:   error_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // Status flags registered from the next state so they never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      resetn_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      resetn_q <= resetn_d;
    end
  end

  // Datapath next state: length capture, word assembly, checksum, write port.
  always_comb begin
    n_d     = n_q;
    bsel_d  = bsel_q;
    widx_d  = widx_q;
    word_d  = word_q;
    xor_d   = xor_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (bus.reboot) begin
      n_d    = 32'd0;
      bsel_d = 2'd0;
      widx_d = '0;
      word_d = 24'd0;
      xor_d  = 8'd0;
    end else if (acc_c) begin
      case (state_q)
        S_LEN: begin
          case (bsel_q)
            2'd0:    n_d[7:0]   = bus.rx_data;
            2'd1:    n_d[15:8]  = bus.rx_data;
            2'd2:    n_d[23:16] = bus.rx_data;
            default: n_d[31:24] = bus.rx_data;
          endcase
          bsel_d = bsel_q + 2'd1;
        end
        S_DATA: begin
          xor_d  = xor_q ^ bus.rx_data;
          bsel_d = bsel_q + 2'd1;
          case (bsel_q)
            2'd0: word_d[7:0]   = bus.rx_data;
            2'd1: word_d[15:8]  = bus.rx_data;
            2'd2: word_d[23:16] = bus.rx_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = widx_q[ADDR_W-1:0];
              wdata_d = {bus.rx_data, word_q};
              widx_d  = widx_inc_c;
            end
          endcase
        end
        default: ;
      endcase
    end
    wmask_d = we_d ? 4'hF : 4'h0;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q     <= 32'd0;
      bsel_q  <= 2'd0;
      widx_q  <= '0;
      word_q  <= 24'd0;
      xor_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      wmask_q <= 4'h0;
    end else begin
      n_q     <= n_d;
      bsel_q  <= bsel_d;
      widx_q  <= widx_d;
      word_q  <= word_d;
      xor_q   <= xor_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign bus.rx_ready    = rx_ready_c;
  assign bus.ld_we       = we_q;
  assign bus.ld_addr     = addr_q;
  assign bus.ld_wdata    = wdata_q;
  assign bus.ld_wmask    = wmask_q;
  assign bus.core_resetn = resetn_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader with a word-level image model.
module tb_boot_loader;

  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_W(AW)) bus ();

  boot_loader #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0]   img_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];

  // Write monitor: record every RAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.ld_we === 1'b1) begin
      wr_addr_q.push_back(bus.ld_addr);
      wr_data_q.push_back(bus.ld_wdata);
      n_cmp++;
      if (bus.ld_wmask !== 4'hF) begin
        n_mis++;
        $display("FAIL wmask: got %0h want f", bus.ld_wmask);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n_cmp++;
    if (bus.rx_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL rx_ready_offer: got %0b want 1", bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n, input int max_gap);
    for (int j = 0; j < 4; j++) send_byte(n[8*j +: 8], max_gap);
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Load img_q; expectations come from the image itself and the checksum choice.
  task automatic load_image(input bit bad_sum, input int max_gap, input string tag);
    logic [7:0]  cs;
    logic [31:0] w;
    bit          exp_run;
    cs = 8'h00;
    clear_writes();
    send_len(32'(img_q.size()), max_gap);
    foreach (img_q[k]) begin
      w = img_q[k];
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8], max_gap);
        cs = cs ^ w[8*j +: 8];
      end
    end
    send_byte(bad_sum ? (cs ^ 8'h01) : cs, max_gap);
    exp_run = !bad_sum;
    n_cmp++;
    if (bus.core_resetn !== exp_run) begin
      n_mis++;
      $display("FAIL %s core_resetn: got %0b want %0b", tag, bus.core_resetn, exp_run);
    end
    n_cmp++;
    if (bus.done !== exp_run) begin
      n_mis++;
      $display("FAIL %s done: got %0b want %0b", tag, bus.done, exp_run);
    end
    n_cmp++;
    if (bus.error !== !exp_run) begin
      n_mis++;
      $display("FAIL %s error: got %0b want %0b", tag, bus.error, !exp_run);
    end
    n_cmp++;
    if (bus.rx_ready !== 1'b0 || bus.busy !== 1'b0) begin
      n_mis++;
      $display("FAIL %s ready_busy: got %0b%0b want 00", tag, bus.rx_ready, bus.busy);
    end
    n_cmp++;
    if (wr_addr_q.size() !== img_q.size()) begin
      n_mis++;
      $display("FAIL %s write_count: got %0d want %0d", tag, wr_addr_q.size(), img_q.size());
    end else begin
      foreach (img_q[k]) begin
        n_cmp++;
        if (wr_addr_q[k] !== AW'(k) || wr_data_q[k] !== img_q[k]) begin
          n_mis++;
          $display("FAIL %s write%0d: got %0h@%0h want %0h@%0h", tag, k,
                   wr_data_q[k], wr_addr_q[k], img_q[k], k);
        end
      end
    end
  endtask

  task automatic do_reboot(input string tag);
    bus.reboot = 1'b1;
    @(negedge clk);
    bus.reboot = 1'b0;
    n_cmp++;
    if (bus.core_resetn !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
        bus.error !== 1'b0 || bus.rx_ready !== 1'b1 || bus.ld_we !== 1'b0) begin
      n_mis++;
      $display("FAIL %s reboot: got resetn=%0b busy=%0b done=%0b err=%0b rdy=%0b we=%0b want 0 1 0 0 1 0",
               tag, bus.core_resetn, bus.busy, bus.done, bus.error, bus.rx_ready, bus.ld_we);
    end
  endtask

  task automatic set_nominal();
    img_q.delete();
    img_q.push_back(32'h0000_0013);
    img_q.push_back(32'hDEAD_BEEF);
  endtask

  task automatic set_random(input int n);
    img_q.delete();
    for (int k = 0; k < n; k++) img_q.push_back($urandom);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.reboot   = 1'b0;
    #1;
    n_cmp++;
    if (bus.ld_we !== 1'b0 || bus.ld_addr !== '0 || bus.ld_wdata !== 32'd0 ||
        bus.ld_wmask !== 4'h0) begin
      n_mis++;
      $display("FAIL reset_write_port: got we=%0b a=%0h d=%0h m=%0h want 0 0 0 0",
               bus.ld_we, bus.ld_addr, bus.ld_wdata, bus.ld_wmask);
    end
    n_cmp++;
    if (bus.core_resetn !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0 ||
        bus.busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_status: got resetn=%0b done=%0b err=%0b busy=%0b rdy=%0b want 0 0 0 1 1",
               bus.core_resetn, bus.done, bus.error, bus.busy, bus.rx_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    set_nominal();
    load_image(1'b0, 0, "nominal");
  endtask

  task automatic test_bad_sum();
    do_reboot("bad_sum");
    set_nominal();
    load_image(1'b1, 0, "bad_sum");
  endtask

  task automatic test_empty();
    do_reboot("empty");
    img_q.delete();
    load_image(1'b0, 0, "empty");
  endtask

  task automatic test_oversize();
    do_reboot("oversize");
    clear_writes();
    send_len(32'(17), 0);
    n_cmp++;
    if (bus.error !== 1'b1 || bus.rx_ready !== 1'b0 || bus.busy !== 1'b0 ||
        bus.core_resetn !== 1'b0) begin
      n_mis++;
      $display("FAIL oversize_err: got err=%0b rdy=%0b busy=%0b resetn=%0b want 1 0 0 0",
               bus.error, bus.rx_ready, bus.busy, bus.core_resetn);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_addr_q.size() !== 0) begin
      n_mis++;
      $display("FAIL oversize_writes: got %0d want 0", wr_addr_q.size());
    end
    do_reboot("max_size");
    set_random(16);
    load_image(1'b0, 0, "max_size");
  endtask

  task automatic test_gaps_reboot();
    do_reboot("gaps");
    set_nominal();
    load_image(1'b0, 5, "gaps");
    do_reboot("run_reboot");
    set_random(int'($urandom_range(8, 1)));
    load_image(1'b0, 3, "reload");
  endtask

  task automatic test_reboot_priority();
    do_reboot("prio");
    clear_writes();
    send_len(32'(3), 0);
    for (int j = 0; j < 3; j++) send_byte(8'($urandom), 0);
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    bus.reboot   = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.reboot   = 1'b0;
    n_cmp++;
    if (bus.ld_we !== 1'b0 || wr_addr_q.size() !== 0 || bus.busy !== 1'b1) begin
      n_mis++;
      $display("FAIL prio_drop: got we=%0b writes=%0d busy=%0b want 0 0 1",
               bus.ld_we, wr_addr_q.size(), bus.busy);
    end
    set_nominal();
    load_image(1'b0, 0, "after_prio");
  endtask

  task automatic test_reset_mid();
    do_reboot("reset_mid");
    clear_writes();
    send_len(32'(2), 0);
    for (int j = 0; j < 6; j++) send_byte(8'($urandom), 0);
    n_cmp++;
    if (wr_addr_q.size() !== 1) begin
      n_mis++;
      $display("FAIL reset_mid_partial: got %0d want 1", wr_addr_q.size());
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.ld_we !== 1'b0 || bus.core_resetn !== 1'b0 || bus.busy !== 1'b1 ||
        bus.rx_ready !== 1'b1 || bus.done !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_mid_async: got we=%0b resetn=%0b busy=%0b rdy=%0b done=%0b want 0 0 1 1 0",
               bus.ld_we, bus.core_resetn, bus.busy, bus.rx_ready, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    set_nominal();
    load_image(1'b0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reboot("random");
      set_random(int'($urandom_range(8, 1)));
      load_image(1'($urandom_range(1, 0)), 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_sum();
    test_empty();
    test_oversize();
    test_gaps_reboot();
    test_reboot_priority();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
